// File: rtl/multi_toggle_gen.sv
// rtl/multi_toggle_gen.sv - multi-channel square-wave generator with run-length auto-finish
module multi_toggle_gen #(
  parameter int CH    = 3,
  parameter int CNT_W = 8,
  parameter int RUN_W = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic [CH*CNT_W-1:0] period_i,
  input  logic [CH-1:0]       init_i,
  input  logic [RUN_W-1:0]    run_len,
  output logic [CH-1:0]       out,
  output logic                busy,
  output logic                done,
  output logic [RUN_W-1:0]    cycle_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [CH*CNT_W-1:0]   period_q, period_d;
  logic [RUN_W-1:0]      run_len_q, run_len_d;
  logic [RUN_W-1:0]      cycle_cnt_q, cycle_cnt_d;
  logic [CH-1:0]         out_q, out_d;
  logic [CNT_W-1:0]      cnt_q [CH];
  logic [CNT_W-1:0]      cnt_d [CH];
  logic [CNT_W-1:0]      per   [CH];

  always_comb begin
    for (int k = 0; k < CH; k++) begin
      per[k] = period_q[k*CNT_W +: CNT_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    run_len_d   = run_len_q;
    cycle_cnt_d = cycle_cnt_q;
    out_d       = out_q;
    for (int k = 0; k < CH; k++) begin
      cnt_d[k] = cnt_q[k];
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          period_d    = period_i;
          run_len_d   = run_len;
          out_d       = init_i;
          cycle_cnt_d = '0;
          for (int k = 0; k < CH; k++) begin
            cnt_d[k] = '0;
          end
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // stop freezes everything on its edge, so it pre-empts both toggling and auto-finish
        if (stop) begin
          state_d = S_IDLE;
        end else begin
          cycle_cnt_d = cycle_cnt_q + RUN_W'(1);
          for (int k = 0; k < CH; k++) begin
            if (per[k] == '0) begin
              cnt_d[k] = '0;
            end else if (cnt_q[k] == per[k] - CNT_W'(1)) begin
              cnt_d[k] = '0;
              out_d[k] = ~out_q[k];
            end else begin
              cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
          end
          if ((run_len_q != '0) && (cycle_cnt_q == run_len_q - RUN_W'(1))) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      period_q    <= '0;
      run_len_q   <= '0;
      cycle_cnt_q <= '0;
      out_q       <= '0;
      for (int k = 0; k < CH; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      run_len_q   <= run_len_d;
      cycle_cnt_q <= cycle_cnt_d;
      out_q       <= out_d;
      for (int k = 0; k < CH; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign out       = out_q;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign cycle_cnt = cycle_cnt_q;

endmodule

// File: doc/multi_toggle_gen.md
# multi_toggle_gen

Synthesizable, parameterised multi-channel square-wave stimulus generator. Each of `CH` output channels toggles with its own programmable half-period, starting from a programmable initial level. A global run-length counter ends the run automatically. It replaces hand-written delay-based toggle stimulus with an on-chip source that can drive a device under test in simulation and on the board.

## Interface
Parameters:
- `CH`, 3, number of output channels.
- `CNT_W`, 8, width of each channel's half-period field.
- `RUN_W`, 12, width of the run-length and cycle counters.

Ports:
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  begins a run; honoured only in IDLE.
- `stop`  in  1  aborts a run; honoured only in RUN.
- `period_i`  in  CH*CNT_W  half-period per channel, in cycles. Channel k uses bits [k*CNT_W +: CNT_W].
- `init_i`  in  CH  initial output level per channel.
- `run_len`  in  RUN_W  number of RUN edges before auto-finish; 0 means free-run.
- `out`  out  CH  channel outputs, registered.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse after an auto-finish.
- `cycle_cnt`  out  RUN_W  count of RUN edges completed in the current or last run.

## Operation
- The state machine has three states: IDLE, RUN, DONE.
- IDLE:
  - On `start`, the block latches `period_i`, `init_i` and `run_len` into internal registers.
  - On the same edge, `out <= init_i`, all channel counters go to 0, `cycle_cnt <= 0`, and the state moves to RUN.
  - Inputs are not re-sampled during the run.
- RUN, on each edge, per channel k with latched period P:
  - If P == 0: `out[k]` holds and its counter stays at 0.
  - Else if cnt_k == P-1: `out[k]` toggles and cnt_k <= 0.
  - Else: cnt_k <= cnt_k + 1.
- RUN, on each edge, the cycle counter does `cycle_cnt <= cycle_cnt + 1`, wrapping modulo 2^RUN_W.
- Auto-finish: if the latched run_len != 0 and `cycle_cnt == run_len-1`, the state goes to DONE on that edge. Channel updates on that edge still apply.
- `stop` in RUN:
  - The state goes to IDLE on that edge and no channel update occurs on it.
  - `out` and `cycle_cnt` hold their values, and `done` is not asserted.
  - `stop` has priority over the channel updates and over auto-finish.
- DONE:
  - `done` = 1 and `out` holds.
  - The next edge unconditionally returns to IDLE, and `start` is ignored in DONE.
- In IDLE, `out` and `cycle_cnt` hold their last values.
- `start` in RUN or DONE is ignored. `stop` in IDLE or DONE is ignored. If `start` and `stop` are both high in IDLE, start wins.
- Reset, including mid-run, applies at the next edge with `rst_n` low:
  - state = IDLE
  - `out` = 0
  - `busy` = 0
  - `done` = 0
  - `cycle_cnt` = 0
  - all channel counters and latched registers = 0

## Timing
- All outputs are registered: `busy` = (state == RUN) and `done` = (state == DONE).
- Let edge T be the edge at which `start` is sampled. For a channel with P > 0:
  - After edge T, `out` = init.
  - `out` = ~init after edge T+P.
  - `out` = init again after edge T+2P.
  - The output therefore has a full period of 2P cycles.
- After edge T+k, `cycle_cnt` = k.
- With run_len = L > 0:
  - The last RUN edge is T+L, and `cycle_cnt` = L after it.
  - `busy` falls after edge T+L.
  - `done` is high for the single cycle between edges T+L and T+L+1.
  - The block is back in IDLE after edge T+L+1, and the earliest accepted restart is at edge T+L+1.
- `stop` sampled at edge S: `busy` is low after S, with `out` frozen at its value after S-1.
- With run_len = 0, the run never finishes on its own: `cycle_cnt` wraps from 2^RUN_W-1 to 0 and the run continues.

## Test plan
- Reset: hold `rst_n` = 0 for 3 edges during a run. Required: `out` = 0, `busy` = 0, `done` = 0, `cycle_cnt` = 0. A `start` after release begins a new run normally.
- Three channels: periods 10/26/47, init 1/0/1, run_len 300. Required:
  - ch0 toggles every 10 edges, ch1 every 26, ch2 every 47.
  - `busy` falls after edge T+300, with `cycle_cnt` = 300.
  - `done` is high for exactly one cycle.
- Period 0 on ch1 with init 1 and run_len 50. Required: ch1 stays 1 for the whole run, and the other channels are unaffected.
- `stop` at edge T+37 with periods 5/5/5 and init 0. Required:
  - `busy` = 0 after T+37, and `cycle_cnt` = 36.
  - `out` = 1 on all channels (the value after edge T+36).
  - `done` never pulses.
- `start` re-asserted at T+5 and again during DONE. Required: both are ignored, with no reload and `cycle_cnt` continuing.
- Free-run: RUN_W = 4, run_len = 0. Required: `cycle_cnt` goes 15 -> 0 and `busy` stays 1 until `stop`.
